// File: rtl/vga_framebuffer.sv
// vga_framebuffer: packed-pixel framebuffer with CPU store port, 2-cycle pixel read and fill engine.
// Define VGA_DOUBLE_BUF_EN for front/back banks swapped at vertical sync.
package vga_pkg;
    typedef struct packed {
        logic       memWrite;
        logic [1:0] size;
    } mem_ctrl_t;
endpackage

module vga_framebuffer
    import vga_pkg::*;
#(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int BPP    = 4,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [31:0]    i_pxlAddr,
    input  logic [31:0]    i_pxlData,
    input  mem_ctrl_t      i_ctrlVGA,
    input  logic           i_rdEn,
    input  logic [XW-1:0]  i_pxlX,
    input  logic [YW-1:0]  i_pxlY,
    output logic [BPP-1:0] o_value,
    output logic           o_valid,
    input  logic           i_fillStart,
    input  logic [BPP-1:0] i_fillColor,
    output logic           o_fillBusy,
    input  logic           i_swap,
    input  logic           i_vsync,
    output logic           o_swapPending
);
    localparam int PPW   = 32 / BPP;
    localparam int WORDS = (WIDTH * HEIGHT + PPW - 1) / PPW;
    localparam int WW    = $clog2(WORDS);
    localparam int PW    = $clog2(PPW);
    localparam int PXW   = WW + PW;
`ifdef VGA_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int AW = $clog2(NB * WORDS);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [31:0]    mem [NB*WORDS];
    logic [0:0]     state;
    logic [WW-1:0]  fill_cnt;
    logic [BPP-1:0] fill_color;
    logic           front, back;
    logic           cpu_we, we;
    logic [3:0]     wbe;
    logic [31:0]    wdata, rd_data;
    logic [AW-1:0]  waddr, raddr;
    logic [PXW-1:0] pix;
    logic           rd_oor, s1_valid, s1_oor;
    logic [PW-1:0]  s1_lane;

    function automatic logic [AW-1:0] bank_addr(input logic b, input logic [WW-1:0] w);
        return b ? AW'(WORDS) + AW'(w) : AW'(w);
    endfunction

    assign o_fillBusy = state == FILL;
    assign cpu_we = i_ctrlVGA.memWrite && i_ctrlVGA.size != 2'b11 && i_pxlAddr[31:2] < 30'(WORDS);
    assign we     = cpu_we || state == FILL;
    assign waddr  = bank_addr(back, cpu_we ? i_pxlAddr[WW+1:2] : fill_cnt);
    assign wdata  = !cpu_we ? {PPW{fill_color}} :
                    i_ctrlVGA.size == 2'b00 ? {4{i_pxlData[7:0]}} :
                    i_ctrlVGA.size == 2'b01 ? {2{i_pxlData[15:0]}} : i_pxlData;
    assign wbe    = !cpu_we ? 4'hf :
                    i_ctrlVGA.size == 2'b00 ? 4'b0001 << i_pxlAddr[1:0] :
                    i_ctrlVGA.size == 2'b01 ? (i_pxlAddr[1] ? 4'b1100 : 4'b0011) : 4'hf;

    // Index is only meaningful in range, where it always fits PXW bits.
    assign pix    = PXW'(32'(i_pxlY) * WIDTH + 32'(i_pxlX));
    assign rd_oor = 32'(i_pxlX) >= WIDTH || 32'(i_pxlY) >= HEIGHT;
    assign raddr  = bank_addr(front, rd_oor ? '0 : pix[PXW-1:PW]);

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++)
            if (we && wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        rd_data <= mem[raddr];
    end

    // A CPU write owns the port; the fill simply holds its index that cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
        end else if (state == IDLE) begin
            if (i_fillStart) begin
                state      <= FILL;
                fill_cnt   <= '0;
                fill_color <= i_fillColor;
            end
        end else if (!cpu_we) begin
            state    <= fill_cnt == WW'(WORDS - 1) ? IDLE : FILL;
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_lane  <= '0;
            o_valid  <= 1'b0;
            o_value  <= '0;
        end else begin
            s1_valid <= i_rdEn;
            s1_oor   <= rd_oor;
            s1_lane  <= pix[PW-1:0];
            o_valid  <= s1_valid;
            o_value  <= s1_valid && !s1_oor ? rd_data[BPP*s1_lane +: BPP] : '0;
        end
    end

`ifdef VGA_DOUBLE_BUF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            front         <= 1'b0;
            o_swapPending <= 1'b0;
        end else if (i_vsync && (o_swapPending || i_swap) && state == IDLE) begin
            front         <= ~front;
            o_swapPending <= 1'b0;
        end else if (i_swap) begin
            o_swapPending <= 1'b1;
        end
    end
    assign back = ~front;
`else
    logic unused_swap;
    assign unused_swap   = i_swap ^ i_vsync;
    assign front         = 1'b0;
    assign back          = 1'b0;
    assign o_swapPending = 1'b0;
`endif
endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: directed self-checking bench for vga_framebuffer.
// Build with VGA_DOUBLE_BUF_EN to exercise the bank swap path.
module tb_vga_framebuffer;
    localparam int WORDS = 2400;

    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] pxl_addr = 0;
    logic [31:0] pxl_data = 0;
    vga_pkg::mem_ctrl_t ctrl = '{memWrite: 1'b0, size: 2'b11};
    logic        rd_en = 0;
    logic [7:0]  pxl_x = 0;
    logic [6:0]  pxl_y = 0;
    logic [3:0]  value;
    logic        valid;
    logic        fill_start = 0;
    logic [3:0]  fill_color = 0;
    logic        fill_busy;
    logic        swap = 0;
    logic        vsync = 0;
    logic        swap_pending;

    int n_cmp = 0;
    int n_bad = 0;

    vga_framebuffer dut (
        .i_clk(clk), .i_rst(rst), .i_pxlAddr(pxl_addr), .i_pxlData(pxl_data),
        .i_ctrlVGA(ctrl), .i_rdEn(rd_en), .i_pxlX(pxl_x), .i_pxlY(pxl_y),
        .o_value(value), .o_valid(valid), .i_fillStart(fill_start),
        .i_fillColor(fill_color), .o_fillBusy(fill_busy), .i_swap(swap),
        .i_vsync(vsync), .o_swapPending(swap_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        pxl_addr = a;
        pxl_data = d;
        ctrl = '{memWrite: 1'b1, size: s};
        tick();
        ctrl = '{memWrite: 1'b0, size: 2'b11};
    endtask

    task automatic rd(input int x, input int y, output logic [3:0] v, output logic ok);
        rd_en = 1;
        pxl_x = 8'(x);
        pxl_y = 7'(y);
        tick();
        rd_en = 0;
        tick();
        v = value;
        ok = valid;
    endtask

    // Fill with colour c; an optional word store is injected at busy-sample st_at,
    // and a stray fillStart with a different colour is pulsed mid-fill.
    task automatic run_fill(input logic [3:0] c, input int st_at, input logic [31:0] a,
                            input logic [31:0] d, output int n);
        fill_color = c;
        fill_start = 1;
        tick();
        fill_start = 0;
        fill_color = ~c;
        n = 0;
        while (fill_busy && n < 5000) begin
            n++;
            fill_start = n == 50;
            if (n == st_at) begin
                pxl_addr = a;
                pxl_data = d;
                ctrl = '{memWrite: 1'b1, size: 2'b10};
            end
            tick();
            fill_start = 0;
            ctrl = '{memWrite: 1'b0, size: 2'b11};
        end
    endtask

    task automatic test_reset();
        rst = 1;
        rd_en = 1;
        repeat (3) tick();
        rst = 0;
        rd_en = 0;
        n_cmp++; if (value !== 4'h0) begin n_bad++; $display("FAIL reset_value: got %h want 0", value); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (fill_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", fill_busy); end
        n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
    endtask

    task automatic test_word_store();
        wr(32'd0, 32'h76543210, 2'b10);
        for (int i = 0; i < 10; i++) begin
            rd_en = i < 8;
            pxl_x = 8'(i);
            pxl_y = 0;
            tick();
            if (i == 0 || i == 9) begin
                n_cmp++;
                if (valid !== 1'b0 || value !== 4'h0) begin
                    n_bad++; $display("FAIL latency_idle%0d: got v=%b %h want v=0 0", i, valid, value);
                end
            end else begin
                n_cmp++;
                if (valid !== 1'b1 || value !== 4'(i - 1)) begin
                    n_bad++; $display("FAIL word_px%0d: got v=%b %h want v=1 %h", i - 1, valid, value, 4'(i - 1));
                end
            end
        end
        rd_en = 0;
    endtask

    task automatic test_byte_half();
        logic [3:0] v;
        logic ok;
        wr(32'd5, 32'h123456AB, 2'b00);
        rd(10, 0, v, ok);
        n_cmp++; if (v !== 4'hB || ok !== 1'b1) begin n_bad++; $display("FAIL byte_px10: got %h want b", v); end
        rd(11, 0, v, ok);
        n_cmp++; if (v !== 4'hA) begin n_bad++; $display("FAIL byte_px11: got %h want a", v); end
        wr(32'd6, 32'h9876CDEF, 2'b01);
        rd(12, 0, v, ok);
        n_cmp++; if (v !== 4'hF) begin n_bad++; $display("FAIL half_px12: got %h want f", v); end
        rd(15, 0, v, ok);
        n_cmp++; if (v !== 4'hC) begin n_bad++; $display("FAIL half_px15: got %h want c", v); end
        rd(10, 0, v, ok);
        n_cmp++; if (v !== 4'hB) begin n_bad++; $display("FAIL half_keeps_byte: got %h want b", v); end
    endtask

    task automatic test_range();
        logic [3:0] v;
        logic ok;
        wr(32'(WORDS * 4), 32'hFFFFFFFF, 2'b10);
        wr(32'(4096 * 4), 32'hFFFFFFFF, 2'b10);
        wr(32'd0, 32'hFFFFFFFF, 2'b11);
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'h0) begin n_bad++; $display("FAIL range_px0: got %h want 0", v); end
        rd(7, 0, v, ok);
        n_cmp++; if (v !== 4'h7) begin n_bad++; $display("FAIL range_px7: got %h want 7", v); end
        wr(32'd80, 32'hFFFFFFFF, 2'b10);
        rd(0, 1, v, ok);
        n_cmp++; if (v !== 4'hF) begin n_bad++; $display("FAIL row1_px0: got %h want f", v); end
        rd(160, 0, v, ok);
        n_cmp++; if (v !== 4'h0 || ok !== 1'b1) begin n_bad++; $display("FAIL oor_x160: got v=%b %h want v=1 0", ok, v); end
        rd(0, 120, v, ok);
        n_cmp++; if (v !== 4'h0 || ok !== 1'b1) begin n_bad++; $display("FAIL oor_y120: got v=%b %h want v=1 0", ok, v); end
    endtask

    task automatic test_fill();
        int n, bad;
        run_fill(4'h5, 0, 0, 0, n);
        n_cmp++; if (n !== 2400) begin n_bad++; $display("FAIL fill_busy_len: got %0d want 2400", n); end
        bad = 0;
        for (int i = 0; i <= 19200; i++) begin
            rd_en = i < 19200;
            pxl_x = 8'(i % 160);
            pxl_y = 7'(i / 160);
            tick();
            if (i >= 1 && (value !== 4'h5 || valid !== 1'b1)) bad++;
        end
        rd_en = 0;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL fill_scan: got %0d bad pixels want 0", bad); end
    endtask

    task automatic test_fill_stall();
        int n;
        logic [3:0] v;
        logic ok;
        run_fill(4'h9, 100, 32'd0, 32'h11111111, n);
        n_cmp++; if (n !== 2401) begin n_bad++; $display("FAIL stall_len_a: got %0d want 2401", n); end
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'h1) begin n_bad++; $display("FAIL stall_survive: got %h want 1", v); end
        rd(8, 0, v, ok);
        n_cmp++; if (v !== 4'h9) begin n_bad++; $display("FAIL stall_word1: got %h want 9", v); end
        rd(152, 119, v, ok);
        n_cmp++; if (v !== 4'h9) begin n_bad++; $display("FAIL stall_last: got %h want 9", v); end
        run_fill(4'h6, 100, 32'(2000 * 4), 32'h22222222, n);
        n_cmp++; if (n !== 2401) begin n_bad++; $display("FAIL stall_len_b: got %0d want 2401", n); end
        rd(0, 100, v, ok);
        n_cmp++; if (v !== 4'h6) begin n_bad++; $display("FAIL stall_overwritten: got %h want 6", v); end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        logic [3:0] v;
        logic ok;
        fill_color = 4'hC;
        fill_start = 1;
        tick();
        fill_start = 0;
        n = 1;
        while (n < 100) begin
            tick();
            n++;
        end
        rst = 1;
        tick();
        rst = 0;
        n_cmp++; if (fill_busy !== 1'b0) begin n_bad++; $display("FAIL midfill_busy: got %b want 0", fill_busy); end
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'hC) begin n_bad++; $display("FAIL midfill_word0: got %h want c", v); end
        rd(152, 4, v, ok);
        n_cmp++; if (v !== 4'hC) begin n_bad++; $display("FAIL midfill_word99: got %h want c", v); end
        rd(0, 5, v, ok);
        n_cmp++; if (v !== 4'h6) begin n_bad++; $display("FAIL midfill_word100: got %h want 6", v); end
    endtask

    task automatic test_reset_start();
        rst = 1;
        fill_start = 1;
        tick();
        rst = 0;
        fill_start = 0;
        n_cmp++; if (fill_busy !== 1'b0) begin n_bad++; $display("FAIL rst_start_busy: got %b want 0", fill_busy); end
        tick();
        n_cmp++; if (fill_busy !== 1'b0) begin n_bad++; $display("FAIL rst_start_idle: got %b want 0", fill_busy); end
    endtask

`ifdef VGA_DOUBLE_BUF_EN
    task automatic test_swap();
        int n;
        logic [3:0] v;
        logic ok;
        run_fill(4'h7, 0, 0, 0, n);
        swap = 1; vsync = 1;
        tick();
        swap = 0; vsync = 0;
        n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL swap_now_pending: got %b want 0", swap_pending); end
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'h7) begin n_bad++; $display("FAIL swap_now_front: got %h want 7", v); end
        run_fill(4'h3, 0, 0, 0, n);
        swap = 1;
        tick();
        swap = 0;
        n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL swap_pending: got %b want 1", swap_pending); end
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'h7) begin n_bad++; $display("FAIL swap_old_front: got %h want 7", v); end
        vsync = 1;
        tick();
        vsync = 0;
        n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL swap_cleared: got %b want 0", swap_pending); end
        rd(5, 7, v, ok);
        n_cmp++; if (v !== 4'h3) begin n_bad++; $display("FAIL swap_new_front: got %h want 3", v); end
        fill_color = 4'hE;
        fill_start = 1;
        tick();
        fill_start = 0;
        swap = 1;
        tick();
        swap = 0;
        vsync = 1;
        tick();
        vsync = 0;
        n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL swap_deferred: got %b want 1", swap_pending); end
        n = 0;
        while (fill_busy && n < 5000) begin
            tick();
            n++;
        end
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'h3) begin n_bad++; $display("FAIL swap_deferred_front: got %h want 3", v); end
        vsync = 1;
        tick();
        vsync = 0;
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'hE || swap_pending !== 1'b0) begin n_bad++; $display("FAIL swap_after_fill: got %h p=%b want e p=0", v, swap_pending); end
    endtask
`else
    task automatic test_swap_ignored();
        logic [3:0] v;
        logic ok;
        swap = 1; vsync = 1;
        tick();
        swap = 0; vsync = 0;
        n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL swap_tied: got %b want 0", swap_pending); end
        rd(0, 0, v, ok);
        n_cmp++; if (v !== 4'hC) begin n_bad++; $display("FAIL swap_no_bank: got %h want c", v); end
    endtask
`endif

    initial begin
        tick();
        test_reset();
`ifdef VGA_DOUBLE_BUF_EN
        test_swap();
`else
        test_word_store();
        test_byte_half();
        test_range();
        test_fill();
        test_fill_stall();
        test_reset_mid_fill();
        test_swap_ignored();
`endif
        test_reset_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Parametrised single-clock pixel framebuffer for the VGA path: the CPU store path writes packed pixel words, the scan-out side reads one pixel per request, and a hardware fill engine clears the whole buffer to one colour. Optional double buffering gives tear-free updates: the scan-out reads a front bank, writes go to a back bank, and the banks swap at vertical sync. It sits between the memory-mapped VGA store port and the VGA timing/DAC stage.

## Interface
- WIDTH, 160, visible pixels per line
- HEIGHT, 120, visible lines
- BPP, 4, bits per pixel; legal values 1, 2, 4, 8
- Derived values:
  - PPW = 32/BPP, pixels per word
  - WORDS = ceil(WIDTH*HEIGHT/PPW)
  - XW = clog2(WIDTH), YW = clog2(HEIGHT)

Ports:
- i_clk  in  1  single clock, shared by the write side and the scan-out side
- i_rst  in  1  synchronous, active-high reset
- i_pxlAddr  in  32  byte offset into the write bank
- i_pxlData  in  32  store data, right-aligned for byte and half stores
- i_ctrlVGA  in  mem_ctrl_t  memWrite strobe; size: 00 byte, 01 half, 10 word, 11 none
- i_rdEn  in  1  pixel read request
- i_pxlX  in  XW  pixel column
- i_pxlY  in  YW  pixel row
- o_value  out  BPP  pixel colour
- o_valid  out  1  o_value qualifier
- i_fillStart  in  1  one-cycle pulse that starts a fill
- i_fillColor  in  BPP  fill colour
- o_fillBusy  out  1  fill in progress
- i_swap  in  1  one-cycle buffer swap request
- i_vsync  in  1  one-cycle pulse at the start of vertical blanking
- o_swapPending  out  1  swap requested but not yet performed

## Operation
- **Write address:** word index = i_pxlAddr[31:2], lane = i_pxlAddr[1:0].
  - The write is performed only when memWrite is high and word index < WORDS. Otherwise it is dropped silently.
  - Byte store writes lane byte 0..3. Half store writes half i_pxlAddr[1]. Word store ignores the lane bits. Size 11 writes nothing.
- **Read address:** pixel index p = i_pxlY*WIDTH + i_pxlX. Word = p/PPW. Pixel within the word = p%PPW; pixel 0 occupies bits [BPP-1:0].
  - Out-of-range read (X >= WIDTH or Y >= HEIGHT): o_value = 0, and o_valid still asserts.
- **Fill FSM, states IDLE and FILL:**
  - IDLE -> FILL on i_fillStart. The word counter is cleared to 0.
  - In FILL, each cycle writes {PPW{i_fillColor}} (colour latched at start) to the counter index, then increments the counter.
  - FILL -> IDLE after index WORDS-1 is written.
  - i_fillStart while in FILL is ignored.
  - A CPU write has priority. In a cycle with a valid CPU write, the fill stalls and retries the same index next cycle.
- **Write bank:** CPU writes and fill both target the back bank (the only bank when double buffering is compiled out).
- **Collision:** a read and a write to the same word in the same cycle return the old data (read-first).

## Timing
- **Reset values:** o_value = 0, o_valid = 0, o_fillBusy = 0, o_swapPending = 0, front bank = 0, FSM = IDLE. Memory contents are not reset.
- **Read latency:** 2 cycles. i_rdEn in cycle N gives o_value/o_valid in cycle N+2.
  - Stage 1 is the registered RAM read plus a registered lane select. Stage 2 is the pixel mux register.
  - Back-to-back reads are accepted every cycle.
  - When the request was not enabled, o_valid = 0 and o_value = 0.
- **Fill timing:**
  - o_fillBusy rises the cycle after i_fillStart.
  - It stays high exactly WORDS cycles plus one per stalled cycle.
  - It falls the cycle after the last word is written.
- **Reset mid-fill:** FSM returns to IDLE and o_fillBusy = 0 on the next edge. Partially filled memory is left as is.
- **Write visibility:** a write is visible to a read issued in the following cycle.
- **Simultaneous events:** i_fillStart together with i_rst means reset wins.

## Configuration
- **VGA_DOUBLE_BUF_EN defined:**
  - Two banks of WORDS words. Reads use the front bank; writes and fill use the other bank.
  - i_swap sets o_swapPending, which is sticky.
  - On an i_vsync pulse with o_swapPending = 1 and o_fillBusy = 0, the front bank toggles and o_swapPending clears on the same edge.
  - i_swap coincident with a qualifying i_vsync is performed immediately.
  - A swap requested during a fill is deferred to the first i_vsync after the fill completes.
  - Bank selection for a read is sampled at request time, so in-flight reads are unaffected by a swap.
- **Not defined:**
  - A single bank: reads and writes share it.
  - i_swap and i_vsync are ignored, and o_swapPending is tied to 0.

## Test plan
- **Reset:** hold i_rst 3 cycles -> o_value = 0, o_valid = 0, o_fillBusy = 0, o_swapPending = 0.
- **Word store and 2-cycle latency:** word store 0x76543210 at address 0, then i_rdEn with X = 0..7, Y = 0 on consecutive cycles -> o_value = 0..7, each 2 cycles after its request.
- **Byte/half stores and address range:**
  - Byte store 0xAB at address 5 -> pixels 10 and 11 read 0xB and 0xA.
  - Store at word index WORDS -> no memory change.
  - Read at X = 160 -> o_value = 0 with o_valid = 1.
- **Fill with stall:**
  - Fill colour 0x5 -> o_fillBusy high 2400 cycles; every pixel then reads 0x5.
  - Repeat with one CPU word store mid-fill -> busy 2401 cycles, and the stored word survives only if its index was already passed.
- **Reset mid-fill:** assert i_rst at fill cycle 100 -> o_fillBusy = 0 next cycle; words 0..99 hold the fill colour.
- **Swap (VGA_DOUBLE_BUF_EN):**
  - Fill back bank with 0x3, then pulse i_swap -> o_swapPending = 1, reads still return the old front data.
  - Next i_vsync -> o_swapPending = 0, and reads return 0x3.
